// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-road traffic light controller.
//   light_e      : per-road 2-bit light encoding
//   phase_e      : controller phase encoding driven on the phase output
//   green_target : green duration for a given traffic level, capped
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'b00,
        YELLOW = 2'b01,
        GREEN  = 2'b10
    } light_e;

    typedef enum logic [1:0] {
        ALL_RED   = 2'b00,
        GREEN_PH  = 2'b01,
        YELLOW_PH = 2'b10
    } phase_e;

    // min(min_g + level*step, max_g), evaluated in 64 bits so it never wraps
    function automatic int unsigned green_target(
        input int unsigned level,
        input int unsigned min_g,
        input int unsigned step,
        input int unsigned max_g
    );
        logic [63:0] t;
        t = 64'(min_g) + 64'(level) * 64'(step);
        if (t > 64'(max_g)) begin
            t = 64'(max_g);
        end
        return 32'(t);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_if.sv
// Bus-side bundle of the N-road traffic light controller.
//   traffic    : per-road traffic level, road r at [r*TRAFFIC_W +: TRAFFIC_W]
//   lights     : per-road light, road r at [2r+1:2r]
//   cur_road   : road owning (or last owning) green
//   phase      : current controller phase
//   emerg_req / emerg_road : only present with EMERGENCY_PREEMPT_EN defined
// master = system bus side, slave = controller side.
interface traffic_light_ctrl_n_if #(
    parameter int unsigned N_ROADS   = 2,
    parameter int unsigned TRAFFIC_W = 3
);
    import traffic_pkg::*;

    localparam int unsigned CR_W = (N_ROADS > 1) ? $clog2(N_ROADS) : 1;

    logic [N_ROADS*TRAFFIC_W-1:0] traffic;
    logic [N_ROADS*2-1:0]         lights;
    logic [CR_W-1:0]              cur_road;
    phase_e                       phase;

`ifdef EMERGENCY_PREEMPT_EN
    logic                         emerg_req;
    logic [CR_W-1:0]              emerg_road;

    modport master (output traffic, emerg_req, emerg_road,
                    input  lights, cur_road, phase);
    modport slave  (input  traffic, emerg_req, emerg_road,
                    output lights, cur_road, phase);
`else
    modport master (output traffic,
                    input  lights, cur_road, phase);
    modport slave  (input  traffic,
                    output lights, cur_road, phase);
`endif

endinterface

// File: rtl/traffic_rr_arb.sv
// Combinational round-robin next-road search.
//   cur_road   : road that owns or last owned green
//   busy       : per-road "traffic level nonzero" vector
//   nxt_road_c : first busy road after cur_road (cur_road itself checked
//                last); cur_road+1 when no road is busy
module traffic_rr_arb
    import traffic_pkg::*;
#(
    parameter int unsigned N_ROADS = 2,
    parameter int unsigned CR_W    = (N_ROADS > 1) ? $clog2(N_ROADS) : 1
) (
    input  logic [CR_W-1:0]    cur_road,
    input  logic [N_ROADS-1:0] busy,
    output logic [CR_W-1:0]    nxt_road_c
);

    logic found;

    // Walk offsets 1..N_ROADS; the first hit wins
    always_comb begin
        found      = 1'b0;
        nxt_road_c = CR_W'((32'(cur_road) + 32'd1) % N_ROADS);
        for (int unsigned i = 1; i <= N_ROADS; i++) begin
            if (!found && busy[CR_W'((32'(cur_road) + i) % N_ROADS)]) begin
                found      = 1'b1;
                nxt_road_c = CR_W'((32'(cur_road) + i) % N_ROADS);
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-road intersection controller: one green road at a time, round-robin
// among roads with traffic, green length scaled by traffic level, fixed
// yellow and all-red clearance phases.
//   CLK, RST_N : clock, synchronous active-low reset
//   bus        : traffic_light_ctrl_n_if.slave (traffic in; lights,
//                cur_road, phase out - all registered)
// Optional macro EMERGENCY_PREEMPT_EN adds emerg_req/emerg_road preemption.
module traffic_light_ctrl_n
    import traffic_pkg::*;
#(
    parameter int unsigned N_ROADS    = 2,
    parameter int unsigned TRAFFIC_W  = 3,
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned GREEN_STEP = 2,
    parameter int unsigned MAX_GREEN  = 16,
    parameter int unsigned YEL_CYC    = 2,
    parameter int unsigned RED_CYC    = 1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    traffic_light_ctrl_n_if.slave  bus
);

    localparam int unsigned CR_W  = (N_ROADS > 1) ? $clog2(N_ROADS) : 1;
    localparam int unsigned TMR_W = (MAX_GREEN > 0) ? $clog2(MAX_GREEN + 1) : 1;

    phase_e               phase_q, phase_d;
    logic [CR_W-1:0]      road_q, road_d;
    logic [TMR_W-1:0]     timer_q, timer_d, timer_inc;
    logic [TMR_W-1:0]     target_q, target_d;
    logic [2*N_ROADS-1:0] lights_q, lights_d;

    logic [TRAFFIC_W-1:0] levels [N_ROADS];
    logic [N_ROADS-1:0]   busy;
    logic                 others_busy;
    logic [CR_W-1:0]      rr_road_c, sel_road_c;
    logic                 red_done, yel_done, green_done;
    logic                 normal_exit_c, normal_restart_c;
    logic                 green_exit_c, green_restart_c;

    // Per-road level slices and nonzero flags
    for (genvar g = 0; g < N_ROADS; g++) begin : g_road
        assign levels[g] = bus.traffic[g*TRAFFIC_W +: TRAFFIC_W];
        assign busy[g]   = |levels[g];
    end

    assign others_busy = |(busy & ~(N_ROADS'(1) << road_q));

    traffic_rr_arb #(
        .N_ROADS (N_ROADS),
        .CR_W    (CR_W)
    ) u_arb (
        .cur_road   (road_q),
        .busy       (busy),
        .nxt_road_c (rr_road_c)
    );

    // Timer counts cycles already spent in the phase; saturates instead of wrapping
    assign timer_inc  = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);
    assign red_done   = (32'(timer_q) + 32'd1) >= RED_CYC;
    assign yel_done   = (32'(timer_q) + 32'd1) >= YEL_CYC;
    assign green_done = (32'(timer_q) + 32'd1) >= 32'(target_q);

    assign normal_exit_c = others_busy &&
                           (green_done ||
                            ((32'(timer_q) >= MIN_GREEN) && (levels[road_q] == '0)));
    assign normal_restart_c = green_done && !others_busy;

`ifdef EMERGENCY_PREEMPT_EN
    logic            emerg_ok_c, preempt_c, emerg_hold_c;
    logic            hold_q;
    logic            pend_q, pend_d;
    logic [CR_W-1:0] pend_road_q, pend_road_d;

    // Requests naming a nonexistent road are ignored
    assign emerg_ok_c   = bus.emerg_req && (32'(bus.emerg_road) < N_ROADS);
    assign preempt_c    = (phase_q == GREEN_PH) && emerg_ok_c && (road_q != bus.emerg_road);
    // hold_q keeps the emergency green one extra cycle after the request drops
    assign emerg_hold_c = (emerg_ok_c && (road_q == bus.emerg_road)) || hold_q;

    assign green_exit_c    = preempt_c || (!emerg_hold_c && normal_exit_c);
    assign green_restart_c = !preempt_c && !emerg_hold_c && normal_restart_c;
    assign sel_road_c      = emerg_ok_c ? bus.emerg_road :
                             (pend_q ? pend_road_q : rr_road_c);
`else
    assign green_exit_c    = normal_exit_c;
    assign green_restart_c = normal_restart_c;
    assign sel_road_c      = rr_road_c;
`endif

    // Next-state logic
    always_comb begin
        phase_d  = phase_q;
        road_d   = road_q;
        timer_d  = timer_inc;
        target_d = target_q;
`ifdef EMERGENCY_PREEMPT_EN
        pend_d      = pend_q;
        pend_road_d = pend_road_q;
`endif
        unique case (phase_q)
            ALL_RED: begin
                if (red_done) begin
                    phase_d  = GREEN_PH;
                    road_d   = sel_road_c;
                    timer_d  = '0;
                    target_d = TMR_W'(green_target(32'(levels[sel_road_c]),
                                                   MIN_GREEN, GREEN_STEP, MAX_GREEN));
                end
            end
            GREEN_PH: begin
                if (green_exit_c) begin
                    phase_d = YELLOW_PH;
                    timer_d = '0;
                end else if (green_restart_c) begin
                    timer_d  = '0;
                    target_d = TMR_W'(green_target(32'(levels[road_q]),
                                                   MIN_GREEN, GREEN_STEP, MAX_GREEN));
                end
            end
            YELLOW_PH: begin
                if (yel_done) begin
                    phase_d = ALL_RED;
                    timer_d = '0;
                end
            end
            default: begin
                phase_d = ALL_RED;
                timer_d = '0;
            end
        endcase
`ifdef EMERGENCY_PREEMPT_EN
        // Pending emergency selection, consumed by the next green grant
        if ((phase_q == ALL_RED) && red_done) begin
            pend_d = 1'b0;
        end else if (preempt_c || (emerg_ok_c && (phase_q != GREEN_PH))) begin
            pend_d      = 1'b1;
            pend_road_d = bus.emerg_road;
        end
`endif
    end

    // Light decode from next state so the lights register tracks phase/road
    always_comb begin
        lights_d = '0;
        for (int unsigned r = 0; r < N_ROADS; r++) begin
            if (road_d == CR_W'(r)) begin
                if (phase_d == GREEN_PH) begin
                    lights_d[2*r +: 2] = GREEN;
                end else if (phase_d == YELLOW_PH) begin
                    lights_d[2*r +: 2] = YELLOW;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            phase_q  <= ALL_RED;
            road_q   <= CR_W'(N_ROADS - 1);
            timer_q  <= '0;
            target_q <= '0;
            lights_q <= '0;
`ifdef EMERGENCY_PREEMPT_EN
            hold_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_road_q <= '0;
`endif
        end else begin
            phase_q  <= phase_d;
            road_q   <= road_d;
            timer_q  <= timer_d;
            target_q <= target_d;
            lights_q <= lights_d;
`ifdef EMERGENCY_PREEMPT_EN
            hold_q      <= emerg_ok_c && (road_q == bus.emerg_road);
            pend_q      <= pend_d;
            pend_road_q <= pend_road_d;
`endif
        end
    end

    assign bus.lights   = lights_q;
    assign bus.cur_road = road_q;
    assign bus.phase    = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Testbench for traffic_light_ctrl_n: a 2-road instance checked cycle by
// cycle against an expected phase/road timeline, and a 3-road instance
// checked for grant order and single non-red road.
// With EMERGENCY_PREEMPT_EN defined, also exercises preemption.
module tb_traffic_light_ctrl_n;
    import traffic_pkg::*;

    typedef struct {
        phase_e ph;
        int     road;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t   exp_q[$];
    int     grant_q[$];
    exp_t   e_cur;
    phase_e prev3;

    always #5 clk = ~clk;

    traffic_light_ctrl_n_if #(.N_ROADS(2), .TRAFFIC_W(3)) bus2 ();
    traffic_light_ctrl_n_if #(.N_ROADS(3), .TRAFFIC_W(3)) bus3 ();

    traffic_light_ctrl_n #(.N_ROADS(2)) dut2 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus2.slave)
    );

    traffic_light_ctrl_n #(.N_ROADS(3)) dut3 (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus3.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] lights_of(input phase_e ph, input int road);
        logic [31:0] v;
        v = '0;
        if (ph == GREEN_PH)       v[2*road +: 2] = 2'b10;
        else if (ph == YELLOW_PH) v[2*road +: 2] = 2'b01;
        return v;
    endfunction

    function automatic int lit_count(input logic [5:0] l);
        int c;
        c = 0;
        for (int r = 0; r < 3; r++) begin
            if (l[2*r +: 2] !== 2'b00) c++;
        end
        return c;
    endfunction

    // One clock: expectation for the state loaded at this edge
    task automatic step(input phase_e ph, input int road);
        exp_t e;
        @(posedge clk);
        e.ph   = ph;
        e.road = road;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic seg(input phase_e ph, input int road, input int n);
        for (int i = 0; i < n; i++) step(ph, road);
    endtask

    task automatic set_tr(input int t0, input int t1);
        bus2.traffic = {3'(t1), 3'(t0)};
    endtask

    // Scoreboard consumers, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            check("phase2",  32'(bus2.phase),    32'(e_cur.ph));
            check("road2",   32'(bus2.cur_road), 32'(e_cur.road));
            check("lights2", 32'(bus2.lights),   lights_of(e_cur.ph, e_cur.road));
        end
        if (mon_en) begin
            check("one_lit3", 32'(lit_count(bus3.lights) <= 1), 32'd1);
            if (bus3.phase == GREEN_PH && prev3 != GREEN_PH) begin
                if (grant_q.size() != 0)
                    check("grant3", 32'(bus3.cur_road), 32'(grant_q.pop_front()));
                else
                    check("grant3_not1", 32'(bus3.cur_road != 2'd1), 32'd1);
            end
        end
        prev3 <= bus3.phase;
    end

    initial begin
        rst_n = 1'b0;
        set_tr(2, 0);
        bus3.traffic = {3'd2, 3'd0, 3'd1};
`ifdef EMERGENCY_PREEMPT_EN
        bus2.emerg_req  = 1'b0;
        bus2.emerg_road = 1'b0;
        bus3.emerg_req  = 1'b0;
        bus3.emerg_road = 2'd0;
`endif
        grant_q = '{0, 2, 0, 2};

        // Reset for three edges, then first grant and hold
        step(ALL_RED, 1);
        mon_en = 1'b1;
        seg(ALL_RED, 1, 2);
        rst_n = 1'b1;
        seg(GREEN_PH, 0, 12);
        set_tr(2, 3);
        seg(GREEN_PH, 0, 4);

        // Alternation 8/2/1 then 10/2/1
        seg(YELLOW_PH, 0, 2);
        seg(ALL_RED, 0, 1);
        seg(GREEN_PH, 1, 10);
        seg(YELLOW_PH, 1, 2);
        seg(ALL_RED, 1, 1);
        seg(GREEN_PH, 0, 8);
        seg(YELLOW_PH, 0, 2);
        seg(ALL_RED, 0, 1);

        // Mid-green change keeps latched target; then capped green of 16
        seg(GREEN_PH, 1, 1);
        set_tr(7, 1);
        seg(GREEN_PH, 1, 9);
        seg(YELLOW_PH, 1, 2);
        seg(ALL_RED, 1, 1);
        seg(GREEN_PH, 0, 16);
        seg(YELLOW_PH, 0, 2);
        seg(ALL_RED, 0, 1);

        // Early exit: road0 target 10 drops to 0 while timer is 5
        seg(GREEN_PH, 1, 1);
        set_tr(3, 4);
        seg(GREEN_PH, 1, 5);
        seg(YELLOW_PH, 1, 2);
        seg(ALL_RED, 1, 1);
        seg(GREEN_PH, 0, 6);
        set_tr(0, 4);
        seg(YELLOW_PH, 0, 2);
        seg(ALL_RED, 0, 1);
        seg(GREEN_PH, 1, 15);

        // Mid-green reset, then all-idle start grants road0 and holds
        rst_n = 1'b0;
        set_tr(0, 0);
        seg(ALL_RED, 1, 2);
        rst_n = 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
        seg(GREEN_PH, 0, 2);
        bus2.emerg_req  = 1'b1;
        bus2.emerg_road = 1'b1;
        seg(YELLOW_PH, 0, 2);
        seg(ALL_RED, 0, 1);
        seg(GREEN_PH, 1, 6);
        rst_n = 1'b0;
        seg(ALL_RED, 1, 1);
        rst_n = 1'b1;
        bus2.emerg_req = 1'b0;
        seg(GREEN_PH, 0, 3);
`else
        seg(GREEN_PH, 0, 6);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        check("grant3_done", 32'(grant_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
